// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: IF/ID register with load-use stall, flush handling and perf counters.
module decode_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  output logic [XLEN-1:0]  id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic             id_issue,
  input  logic             ex_ready,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  state_t state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic id_valid, use_rs1, use_rs2, hazard, load;
  logic [6:0] op;
  assign op = instr_q[6:0];
  assign id_instr = instr_q;
  assign id_pc = pc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  always_comb begin
    id_valid = state_q != EMPTY;
    use_rs2 = op inside {7'h33, 7'h23, 7'h63};
    use_rs1 = use_rs2 | (op inside {7'h03, 7'h13, 7'h67});
    hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) &
             ((use_rs1 & (instr_q[19:15] == ex_rd)) | (use_rs2 & (instr_q[24:20] == ex_rd)));
    id_issue = id_valid & ~hazard & ex_ready & ~flush;
    if_ready = ~id_valid | id_issue | flush;
    illegal_op = id_valid & ~(op inside {7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h67, 7'h17, 7'h37, 7'h6F});
    load = if_valid & if_ready & ~flush;
    state_d = flush ? EMPTY : load ? FULL : (id_issue | ~id_valid) ? EMPTY : hazard ? STALL : FULL;
    instr_d = flush ? NOP : load ? if_instr : id_issue ? NOP : instr_q;
    pc_d = load ? if_pc : pc_q;
    // a flushed cycle is charged to flush_cnt only, never to stall_cnt
    stall_d = (id_valid & ~id_issue & ~flush & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (id_valid & flush & ~&flush_q) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      instr_q <= NOP;
      pc_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed vectors for decode_issue_ctrl with hand-computed expectations.
module tb_decode_issue_ctrl;
  logic clk = 0, rst = 0;
  logic if_valid = 0, ex_ready = 1, ex_valid = 0, ex_is_load = 0, flush = 0;
  logic [31:0] if_instr = 0, if_pc = 0;
  logic [4:0] ex_rd = 0;
  logic if_ready, id_issue, illegal_op;
  logic [31:0] id_instr, id_pc;
  logic [15:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  decode_issue_ctrl dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .id_instr(id_instr), .id_pc(id_pc), .id_issue(id_issue),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .flush(flush), .illegal_op(illegal_op), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic ex_load(input logic [4:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
  endtask
  initial begin
    #2 rst = 1;
    @(negedge clk);
    check("rst if_ready", if_ready, 1);
    check("rst id_issue", id_issue, 0);
    check("rst illegal", illegal_op, 0);
    check("rst id_instr", id_instr, 32'h13);
    check("rst id_pc", id_pc, 0);
    check("rst stall_cnt", stall_cnt, 0);
    check("rst flush_cnt", flush_cnt, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    if_valid = 1; if_instr = 32'h00A00093; if_pc = 32'h100;
    @(negedge clk);
    if_instr = 32'h00208133; if_pc = 32'h104;
    #1;
    check("b2b instr0", id_instr, 32'h00A00093);
    check("b2b pc0", id_pc, 32'h100);
    check("b2b issue0", id_issue, 1);
    check("b2b ready0", if_ready, 1);
    @(negedge clk);
    if_valid = 0;
    #1;
    check("b2b instr1", id_instr, 32'h00208133);
    check("b2b pc1", id_pc, 32'h104);
    check("b2b issue1", id_issue, 1);
    check("b2b stall_cnt", stall_cnt, 0);
    @(negedge clk);
    check("drain nop", id_instr, 32'h13);
    check("drain ready", if_ready, 1);
    check("drain issue", id_issue, 0);
    if_valid = 1; if_instr = 32'h00208133; if_pc = 32'h200;
    @(negedge clk);
    if_valid = 0; ex_load(5'd1);
    #1;
    check("hz issue", id_issue, 0);
    check("hz ready", if_ready, 0);
    @(negedge clk);
    ex_valid = 0; ex_is_load = 0;
    #1;
    check("hz stall_cnt", stall_cnt, 1);
    check("hz held", id_instr, 32'h00208133);
    check("hz reissue", id_issue, 1);
    @(negedge clk);
    if_valid = 1; if_instr = 32'h00208133; if_pc = 32'h300;
    @(negedge clk);
    if_instr = 32'h123450B7; if_pc = 32'h304; ex_load(5'd0);
    #1;
    check("rd0 issue", id_issue, 1);
    @(negedge clk);
    if_valid = 0; ex_load(5'd1);
    #1;
    check("lui instr", id_instr, 32'h123450B7);
    check("lui issue", id_issue, 1);
    check("lui stall_cnt", stall_cnt, 1);
    @(negedge clk);
    ex_valid = 0; ex_is_load = 0;
    if_valid = 1; if_instr = 32'h00208133; if_pc = 32'h400;
    @(negedge clk);
    if_valid = 0; ex_load(5'd2);
    #1;
    check("hz2 issue", id_issue, 0);
    @(negedge clk);
    flush = 1; if_valid = 1; if_instr = 32'h00500113; if_pc = 32'h404;
    #1;
    check("fl issue", id_issue, 0);
    check("fl ready", if_ready, 1);
    check("fl pre stall", stall_cnt, 2);
    @(negedge clk);
    flush = 0; if_valid = 0; ex_valid = 0; ex_is_load = 0;
    #1;
    check("fl nop", id_instr, 32'h13);
    check("fl empty", if_ready, 1);
    check("fl no issue", id_issue, 0);
    check("fl flush_cnt", flush_cnt, 1);
    check("fl stall_cnt", stall_cnt, 2);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("fl empty cnt", flush_cnt, 1);
    if_valid = 1; if_instr = 32'hFFFFFFFF; if_pc = 32'h500;
    @(negedge clk);
    if_valid = 0;
    #1;
    check("ill flag", illegal_op, 1);
    check("ill issue", id_issue, 1);
    @(negedge clk);
    check("ill clear", illegal_op, 0);
    if_valid = 1; if_instr = 32'h00A00093; if_pc = 32'h600; ex_ready = 0;
    @(negedge clk);
    if_valid = 0;
    for (int k = 0; k < 7; k++) begin
      repeat (10000) @(negedge clk);
      check("sat instr", id_instr, 32'h00A00093);
    end
    check("sat stall_cnt", stall_cnt, 32'hFFFF);
    check("sat ready", if_ready, 0);
    check("sat issue", id_issue, 0);
    rst = 1;
    #1;
    check("mid rst instr", id_instr, 32'h13);
    check("mid rst pc", id_pc, 0);
    check("mid rst ready", if_ready, 1);
    check("mid rst stall", stall_cnt, 0);
    check("mid rst flush", flush_cnt, 0);
    check("mid rst issue", id_issue, 0);
    @(negedge clk);
    rst = 0; ex_ready = 1;
    @(negedge clk);
    check("post rst ready", if_ready, 1);
    check("post rst issue", id_issue, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
